// File: rtl/mouse_receiver.sv
// PS/2 mouse receive path: synchronizes the PS/2 clock/data pins, deframes
// 11-bit frames (start, 8 data LSB-first, odd parity, stop) and reports each byte with error flags.
module mouse_receiver #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    input  logic       READ_ENABLE,
    output logic       BYTE_READ,
    output logic [1:0] BYTE_ERROR_CODE,
    output logic [7:0] BYTE
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic            clk_meta, clk_sync, clk_prev;
    logic            data_meta, data_sync;
    logic [2:0]      bit_cnt, bit_cnt_nxt;
    logic [TO_W-1:0] timeout_cnt, timeout_nxt;
    logic [7:0]      shift_reg, shift_nxt;
    logic            parity_bit, parity_bit_nxt;
    logic            stop_err, stop_err_nxt;
    logic            fe_c;
    logic            in_frame_c;

    // Clock flops reset high so releasing reset never looks like a falling edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b0;
            data_sync <= 1'b0;
        end else begin
            clk_meta  <= CLK_MOUSE_IN;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= DATA_MOUSE_IN;
            data_sync <= data_meta;
        end
    end

    assign fe_c       = clk_prev & ~clk_sync;
    assign in_frame_c = (state == DATA) || (state == PARITY) || (state == STOP);

    // Frame sequencing, bit collection and inter-edge timeout.
    always_comb begin
        state_nxt      = state;
        bit_cnt_nxt    = bit_cnt;
        shift_nxt      = shift_reg;
        parity_bit_nxt = parity_bit;
        stop_err_nxt   = stop_err;
        timeout_nxt    = fe_c ? '0 : timeout_cnt + TO_W'(1);

        case (state)
            IDLE: begin
                timeout_nxt = '0;
                bit_cnt_nxt = '0;
                if (fe_c && !data_sync && READ_ENABLE) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (fe_c) begin
                    shift_nxt = {data_sync, shift_reg[7:1]};
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = PARITY;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (fe_c) begin
                    parity_bit_nxt = data_sync;
                    state_nxt      = STOP;
                end
            end
            STOP: begin
                if (fe_c) begin
                    stop_err_nxt = ~data_sync;
                    state_nxt    = DONE;
                end
            end
            DONE: begin
                timeout_nxt = '0;
                state_nxt   = IDLE;
            end
            default: begin
                timeout_nxt = '0;
                state_nxt   = IDLE;
            end
        endcase

        // A stalled mouse clock abandons the frame, even if an edge arrives this cycle.
        if (in_frame_c && (timeout_cnt == TO_LAST)) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
            timeout_nxt = '0;
            shift_nxt   = shift_reg;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            timeout_cnt <= '0;
            shift_reg   <= '0;
            parity_bit  <= 1'b0;
            stop_err    <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            timeout_cnt <= timeout_nxt;
            shift_reg   <= shift_nxt;
            parity_bit  <= parity_bit_nxt;
            stop_err    <= stop_err_nxt;
        end
    end

    // Delivery registers; byte and error code hold until the next completed frame.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            BYTE_READ       <= 1'b0;
            BYTE            <= 8'h00;
            BYTE_ERROR_CODE <= 2'b00;
        end else begin
            BYTE_READ <= (state == DONE);
            if (state == DONE) begin
                BYTE            <= shift_reg;
                BYTE_ERROR_CODE <= {stop_err, ~(^{shift_reg, parity_bit})};
            end
        end
    end

endmodule

// File: tb/tb_mouse_receiver.sv
// Self-checking bench for mouse_receiver: table vectors, hand sequences for
// timeout/reset/latency corners, and randomized frames against a frame-level model.
module tb_mouse_receiver;

    localparam int unsigned T    = 200;
    localparam int          HALF = 20;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       ck_m;
    logic       dt_m;
    logic       re;
    logic       byte_read;
    logic [1:0] err_code;
    logic [7:0] rx_byte;

    int checks   = 0;
    int failures = 0;

    logic [9:0] got[$];
    logic [7:0] last_byte;
    logic [1:0] last_err;

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       s;
        logic       re;
        logic       drop;
        int         n;
        logic [7:0] b;
        logic [1:0] e;
    } vec_t;

    vec_t vecs[7];

    mouse_receiver #(.TIMEOUT_CYCLES(T)) dut (
        .CLK            (CLK),
        .RESET_N        (rst_n),
        .CLK_MOUSE_IN   (ck_m),
        .DATA_MOUSE_IN  (dt_m),
        .READ_ENABLE    (re),
        .BYTE_READ      (byte_read),
        .BYTE_ERROR_CODE(err_code),
        .BYTE           (rx_byte)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (byte_read === 1'b1) got.push_back({err_code, rx_byte});
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic ps2_bit(input logic b, input int hi);
        dt_m = b;
        wait_cyc(hi);
        ck_m = 1'b0;
        wait_cyc(HALF);
        ck_m = 1'b1;
    endtask

    // gap0 = cycles between the start-bit fall and the first data-bit fall.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input logic drop_re, input int gap0);
        ps2_bit(1'b0, HALF);
        if (drop_re) re = 1'b0;
        ps2_bit(d[0], gap0 - HALF);
        for (int i = 1; i < 8; i++) ps2_bit(d[i], HALF);
        ps2_bit(p, HALF);
        ps2_bit(s, HALF);
        dt_m = 1'b1;
    endtask

    // Odd parity over data+parity is correct; a low stop bit is an error.
    function automatic logic [1:0] model_err(input logic [7:0] d, input logic p, input logic s);
        logic perr;
        perr = ($countones({d, p}) % 2) == 0;
        return {~s, perr};
    endfunction

    task automatic expect_frame(input string name, input int n, input logic [7:0] b,
                                input logic [1:0] e);
        wait_cyc(8);
        chk({name, " pulses"}, 32'(got.size()), 32'(n));
        if (n == 1 && got.size() == 1) begin
            chk({name, " byte"}, 32'(got[0][7:0]), 32'(b));
            chk({name, " err"}, 32'(got[0][9:8]), 32'(e));
            last_byte = b;
            last_err  = e;
        end else if (n == 0) begin
            chk({name, " byte hold"}, 32'(rx_byte), 32'(last_byte));
            chk({name, " err hold"}, 32'(err_code), 32'(last_err));
        end
        got.delete();
    endtask

    initial begin
        logic [7:0] d;
        logic       p, s, r, dr;
        logic [7:0] b2b[3];

        vecs[0] = '{8'h08, 1'b0, 1'b1, 1'b1, 1'b0, 1, 8'h08, 2'b00};
        vecs[1] = '{8'hFA, 1'b0, 1'b1, 1'b1, 1'b0, 1, 8'hFA, 2'b01};
        vecs[2] = '{8'hFA, 1'b1, 1'b0, 1'b1, 1'b0, 1, 8'hFA, 2'b10};
        vecs[3] = '{8'hAA, 1'b1, 1'b1, 1'b0, 1'b0, 0, 8'h00, 2'b00};
        vecs[4] = '{8'hFA, 1'b0, 1'b0, 1'b1, 1'b0, 1, 8'hFA, 2'b11};
        vecs[5] = '{8'hAA, 1'b1, 1'b1, 1'b1, 1'b1, 1, 8'hAA, 2'b00};
        vecs[6] = '{8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 1, 8'h55, 2'b00};

        rst_n = 1'b0; ck_m = 1'b1; dt_m = 1'b1; re = 1'b1;
        last_byte = 8'h00; last_err = 2'b00;
        wait_cyc(3);
        chk("reset byte_read", 32'(byte_read), 32'(0));
        chk("reset byte", 32'(rx_byte), 32'(0));
        chk("reset err", 32'(err_code), 32'(0));
        rst_n = 1'b1;
        wait_cyc(6);
        chk("no pulse on release", 32'(got.size()), 32'(0));

        for (int i = 0; i < 7; i++) begin
            re = vecs[i].re;
            send_frame(vecs[i].d, vecs[i].p, vecs[i].s, vecs[i].drop, 2 * HALF);
            re = 1'b1;
            expect_frame($sformatf("vec%0d", i), vecs[i].n, vecs[i].b, vecs[i].e);
        end

        // Reset mid-frame after three data bits (BYTE currently 0x55).
        ps2_bit(1'b0, HALF);
        ps2_bit(1'b1, HALF);
        ps2_bit(1'b0, HALF);
        ps2_bit(1'b1, HALF);
        dt_m = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("midreset byte_read", 32'(byte_read), 32'(0));
        chk("midreset byte", 32'(rx_byte), 32'(0));
        chk("midreset err", 32'(err_code), 32'(0));
        wait_cyc(4);
        rst_n = 1'b1;
        last_byte = 8'h00; last_err = 2'b00;
        wait_cyc(4);
        got.delete();
        send_frame(8'hF4, 1'b0, 1'b1, 1'b0, 2 * HALF);
        expect_frame("after reset", 1, 8'hF4, 2'b00);

        // Stalled mouse clock mid-frame, then a clean frame.
        ps2_bit(1'b0, HALF);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, HALF);
        dt_m = 1'b1;
        wait_cyc(int'(T) + 20);
        expect_frame("timeout", 0, 8'h00, 2'b00);
        send_frame(8'h00, 1'b1, 1'b1, 1'b0, 2 * HALF);
        expect_frame("post timeout", 1, 8'h00, 2'b00);

        // Edge gap at the timeout boundary: T-1 survives, T abandons.
        send_frame(8'hFF, 1'b1, 1'b1, 1'b1, int'(T) - 1);
        re = 1'b1;
        expect_frame("gap T-1", 1, 8'hFF, 2'b00);
        send_frame(8'h0F, 1'b1, 1'b1, 1'b1, int'(T));
        re = 1'b1;
        expect_frame("gap T", 0, 8'h00, 2'b00);

        // Latency: strobe exactly on the 4th edge after the stop-bit pin fall.
        ps2_bit(1'b0, HALF);
        for (int i = 0; i < 8; i++) ps2_bit(((8'h3C >> i) & 8'h01) != 0, HALF);
        ps2_bit(1'b1, HALF);
        dt_m = 1'b1;
        wait_cyc(HALF);
        ck_m = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            wait_cyc(1);
            chk($sformatf("latency edge%0d", k), 32'(byte_read), 32'(k == 4));
        end
        wait_cyc(HALF - 5);
        ck_m = 1'b1;
        expect_frame("latency frame", 1, 8'h3C, 2'b00);

        // Back-to-back frames.
        b2b[0] = 8'h08; b2b[1] = 8'h01; b2b[2] = 8'hFF;
        for (int i = 0; i < 3; i++)
            send_frame(b2b[i], ($countones(b2b[i]) % 2) == 0, 1'b1, 1'b0, 2 * HALF);
        wait_cyc(8);
        chk("b2b pulses", 32'(got.size()), 32'(3));
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            chk($sformatf("b2b byte%0d", i), 32'(got[i][7:0]), 32'(b2b[i]));
            chk($sformatf("b2b err%0d", i), 32'(got[i][9:8]), 32'(0));
        end
        if (got.size() == 3) begin
            last_byte = 8'hFF; last_err = 2'b00;
        end
        got.delete();

        // Randomized frames against the frame-level model.
        for (int i = 0; i < 25; i++) begin
            d  = 8'($urandom);
            p  = 1'($urandom);
            s  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 4) != 0);
            dr = 1'($urandom);
            re = r;
            send_frame(d, p, s, dr, 2 * HALF);
            re = 1'b1;
            expect_frame($sformatf("rand%0d", i), r ? 1 : 0, d, model_err(d, p, s));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mouse_receiver.md
MOUSE_RECEIVER -- requirements
Module: mouse_receiver

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, SHALL set the maximum CLK cycles allowed between mouse-clock falling edges inside a frame (1 ms at 50 MHz).
REQ-002 CLK  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 RESET_N  input  1  reset; asynchronous and active-low.
REQ-004 CLK_MOUSE_IN  input  1  PS/2 clock line as seen at the pin; asynchronous to CLK.
REQ-005 DATA_MOUSE_IN  input  1  PS/2 data line as seen at the pin; asynchronous to CLK.
REQ-006 READ_ENABLE  input  1  high permits a new frame to start.
REQ-007 BYTE_READ  output  1  single-cycle strobe marking a completed frame.
REQ-008 BYTE_ERROR_CODE  output  2  bit0 = parity error, bit1 = stop-bit error; valid with BYTE_READ.
REQ-009 BYTE  output  8  received data byte; valid with BYTE_READ.

Function
REQ-010 CLK_MOUSE_IN and DATA_MOUSE_IN SHALL each pass through a 2-flop synchronizer before use.
REQ-011 A mouse-clock falling edge (FE) SHALL be flagged for exactly one CLK cycle when the synchronized clock is 0 and its previous-cycle value is 1.
REQ-012 All data sampling SHALL use the synchronized data value in the cycle FE is flagged.
REQ-013 The FSM SHALL have states IDLE, DATA, PARITY, STOP, DONE.
REQ-014 IDLE -> DATA on FE with sampled data = 0 (start bit) and READ_ENABLE = 1. Otherwise the FSM SHALL remain in IDLE.
REQ-015 READ_ENABLE SHALL be sampled only in IDLE. Deasserting it mid-frame SHALL NOT abort the frame.
REQ-016 DATA: each FE SHALL shift the sampled bit into the shift register LSB-first. The bit counter SHALL run 0..7. After the 8th bit the FSM SHALL go to PARITY and the counter SHALL return to 0.
REQ-017 PARITY: on FE the sampled bit SHALL be stored. Parity error = (XOR of the 8 data bits and the parity bit) == 0, i.e. odd parity is expected. Next state is STOP.
REQ-018 STOP: on FE, stop error = (sampled bit == 0). Next state is DONE.
REQ-019 DONE SHALL last exactly one cycle and then return to IDLE. In that cycle:
  - BYTE_READ = 1
  - BYTE = shift register contents
  - BYTE_ERROR_CODE = {stop error, parity error}
REQ-020 BYTE and BYTE_ERROR_CODE SHALL be registered and hold their values until the next DONE.
REQ-021 A frame with errors SHALL still be delivered (BYTE_READ = 1) with the nonzero error code.
REQ-022 A timeout counter SHALL be cleared on every FE and while in IDLE, and SHALL increment each cycle in DATA, PARITY and STOP.
REQ-023 When the timeout counter reaches TIMEOUT_CYCLES-1, the FSM SHALL return to IDLE on the next cycle:
  - no BYTE_READ is issued
  - the bit counter and timeout counter are cleared
  - BYTE and BYTE_ERROR_CODE are unchanged
REQ-024 If FE and timeout coincide, the timeout SHALL take priority.
REQ-025 Counter widths SHALL hold TIMEOUT_CYCLES without wrap. The bit counter SHALL be 3 bits.
REQ-026 The block SHALL never drive the PS/2 lines; it is receive-only.
REQ-027 Latency: BYTE_READ SHALL assert exactly 2 CLK cycles after the cycle in which the stop-bit FE is flagged (STOP -> DONE register, DONE output register).

Reset
REQ-028 While RESET_N = 0, regardless of CLK:
  - FSM = IDLE
  - BYTE_READ = 0, BYTE = 8'h00, BYTE_ERROR_CODE = 2'b00
  - all counters, synchronizers and the shift register = 0, except the synchronizer clock flops, which SHALL reset to 1 so no FE is flagged on release
REQ-029 Reset asserted mid-frame SHALL discard the partial frame. The next full frame after release SHALL be received correctly.

Verification
REQ-030 Frame start = 0, data 0x08, parity 0, stop 1, READ_ENABLE = 1 -> one BYTE_READ pulse, BYTE = 0x08, BYTE_ERROR_CODE = 00.
REQ-031 Frame data 0xFA, parity 0 (wrong), stop 1 -> BYTE_READ pulse, BYTE = 0xFA, BYTE_ERROR_CODE = 01. Same frame with parity 1 and stop 0 -> BYTE_ERROR_CODE = 10.
REQ-032 Frame start plus 4 data bits, then the mouse clock held high for 50000 cycles -> no BYTE_READ and FSM in IDLE. A following frame of 0x00 with parity 1 -> BYTE = 0x00, BYTE_ERROR_CODE = 00.
REQ-033 READ_ENABLE = 0 during a full 0xAA frame -> no BYTE_READ. READ_ENABLE dropped after the start bit of a 0xAA frame with parity 1 -> BYTE_READ with BYTE = 0xAA, BYTE_ERROR_CODE = 00.
REQ-034 RESET_N pulsed low after bit 3 of a frame -> outputs at reset values during reset. A subsequent 0xF4 frame with parity 0 -> BYTE = 0xF4, BYTE_ERROR_CODE = 00.
REQ-035 Back-to-back frames 0x08, 0x01, 0xFF with no gap (mouse clock about 15 kHz, CLK 50 MHz) -> exactly three BYTE_READ pulses, bytes in order, all error codes 00.
